// File: rtl/sys_arr_ctrl.sv
// rtl/sys_arr_ctrl.sv - sequencer for an M x M output-stationary systolic array
// Clears the PEs, feeds skewed operand beats, waits for the wavefront, then drains rows.
module sys_arr_ctrl #(
  parameter int M       = 4,
  parameter int K_MAX   = 16,
  parameter int ACC_LAT = 1,
  localparam int IDX_W  = $clog2(K_MAX),
  localparam int T_W    = $clog2(K_MAX + 2*M),
  localparam int RW     = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W:0]       k_len,
  input  logic                 feed_rdy,
  input  logic                 drain_rdy,
  output logic                 busy,
  output logic                 err,
  output logic                 acc_clr,
  output logic [M-1:0]         feed_vld,
  output logic [M*IDX_W-1:0]   lane_idx,
  output logic                 drain_vld,
  output logic [RW-1:0]        drain_row,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  localparam logic [T_W-1:0] FLUSH_LAST = T_W'(M - 2 + ACC_LAT);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(M - 1);

  state_t           state, state_nx;
  logic [T_W-1:0]   t;
  logic [RW-1:0]    r;
  logic [IDX_W:0]   klen;
  logic             start_ok;
  logic [T_W-1:0]   feed_last;

  assign start_ok  = (k_len != '0) && (k_len <= (IDX_W+1)'(K_MAX));
  // Last skewed beat: lane M-1 consumes its final k index at t = k_len+M-2.
  assign feed_last = T_W'(klen) + T_W'(M - 2);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && start_ok) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_FEED;
      S_FEED:  if (feed_rdy && (t == feed_last)) state_nx = S_FLUSH;
      S_FLUSH: if (t == FLUSH_LAST) state_nx = S_DRAIN;
      S_DRAIN: if (drain_rdy && (r == ROW_LAST)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // t is shared: beat index during FEED, wavefront delay during FLUSH.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      t    <= '0;
      r    <= '0;
      klen <= '0;
      err  <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start && !start_ok;
      case (state)
        S_IDLE: begin
          t <= '0;
          r <= '0;
          if (start && start_ok) klen <= k_len;
        end
        S_CLEAR: t <= '0;
        S_FEED: if (feed_rdy) t <= (t == feed_last) ? '0 : t + 1'b1;
        S_FLUSH: begin
          t <= (t == FLUSH_LAST) ? '0 : t + 1'b1;
          r <= '0;
        end
        S_DRAIN: if (drain_rdy && (r != ROW_LAST)) r <= r + 1'b1;
        default: begin
          t <= '0;
          r <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    acc_clr   = (state == S_CLEAR);
    drain_vld = (state == S_DRAIN);
    drain_row = (state == S_DRAIN) ? r : '0;
    done      = (state == S_DONE);
    feed_vld  = '0;
    lane_idx  = '0;
    if (state == S_FEED) begin
      for (int i = 0; i < M; i++) begin
        if ((t >= T_W'(i)) && ((t - T_W'(i)) < T_W'(klen))) begin
          feed_vld[i]                 = 1'b1;
          lane_idx[i*IDX_W +: IDX_W]  = IDX_W'(t - T_W'(i));
        end
      end
    end
  end

endmodule
